// File: rtl/sdrc_app_arbiter.sv
// Round-robin arbiter sharing the sdrc_core application port between NREQ requesters.
// One transaction is in flight at a time; the grant is held until its data phase completes.
module sdrc_app_arbiter #(
  parameter int NREQ   = 4,
  parameter int APP_AW = 26,
  parameter int APP_DW = 32,
  parameter int APP_BW = 4,
  parameter int BL     = 9,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                     sdram_clk,
  input  logic                     sdram_resetn,
  input  logic [NREQ-1:0]          r_req,
  input  logic [NREQ*APP_AW-1:0]   r_addr,
  input  logic [NREQ*BL-1:0]       r_len,
  input  logic [NREQ-1:0]          r_wr_n,
  output logic [NREQ-1:0]          r_ack,
  input  logic [NREQ*APP_DW-1:0]   r_wr_data,
  input  logic [NREQ*APP_BW-1:0]   r_wr_en_n,
  output logic [NREQ-1:0]          r_wr_next,
  output logic [NREQ-1:0]          r_rd_valid,
  output logic [NREQ-1:0]          r_last_rd,
  output logic [APP_DW-1:0]        r_rd_data,
  output logic                     app_req,
  output logic [APP_AW-1:0]        app_req_addr,
  output logic [BL-1:0]            app_req_len,
  output logic                     app_req_wr_n,
  input  logic                     app_req_ack,
  output logic [APP_DW-1:0]        app_wr_data,
  output logic [APP_BW-1:0]        app_wr_en_n,
  input  logic                     app_wr_next_req,
  input  logic                     app_rd_valid,
  input  logic                     app_last_rd,
  input  logic [APP_DW-1:0]        app_rd_data,
  output logic [IDW-1:0]           grant_id,
  output logic                     arb_busy,
  output logic                     arb_err
);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

  state_t            state_q, state_d;
  logic              app_req_q, app_req_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [BL-1:0]     len_q, len_d;
  logic              wr_n_q, wr_n_d;
  logic [BL-1:0]     beat_q, beat_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic              err_q, err_d;

  logic              found;
  logic [IDW-1:0]    cand;
  logic [IDW-1:0]    try_idx;
  logic [BL-1:0]     cand_len;

  // First asserted request after the last acknowledged winner, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    cand    = '0;
    try_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      try_idx = IDW'((int'(rr_q) + k) % NREQ);
      if (!found && r_req[try_idx]) begin
        found = 1'b1;
        cand  = try_idx;
      end
    end
  end

  assign cand_len = r_len[int'(cand)*BL +: BL];

  always_comb begin
    state_d   = state_q;
    app_req_d = app_req_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wr_n_d    = wr_n_q;
    beat_d    = beat_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    err_d     = err_q
              | (app_rd_valid    && (state_q != RDATA))
              | (app_wr_next_req && (state_q != WDATA))
              | (app_req_ack     && (state_q != REQ));
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = REQ;
          app_req_d = 1'b1;
          addr_d    = r_addr[int'(cand)*APP_AW +: APP_AW];
          len_d     = (cand_len == '0) ? BL'(1) : cand_len;
          beat_d    = (cand_len == '0) ? BL'(1) : cand_len;
          wr_n_d    = r_wr_n[cand];
          grant_d   = cand;
        end
      end
      REQ: begin
        if (app_req_ack) begin
          rr_d      = grant_q;
          app_req_d = 1'b0;
          state_d   = wr_n_q ? RDATA : WDATA;
        end
      end
      WDATA: begin
        if (app_wr_next_req) begin
          beat_d = beat_q - BL'(1);
          if (beat_q == BL'(1)) state_d = IDLE;
        end
      end
      RDATA: begin
        if (app_rd_valid && app_last_rd) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q   <= IDLE;
      app_req_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      wr_n_q    <= 1'b1;
      beat_q    <= '0;
      grant_q   <= '0;
      rr_q      <= IDW'(NREQ - 1);
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      app_req_q <= app_req_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wr_n_q    <= wr_n_d;
      beat_q    <= beat_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
    end
  end

  // Core strobes reach only the granted requester, and only in the matching phase.
  always_comb begin
    r_ack       = '0;
    r_wr_next   = '0;
    r_rd_valid  = '0;
    r_last_rd   = '0;
    app_wr_en_n = '1;
    case (state_q)
      REQ:   r_ack[grant_q] = app_req_ack;
      WDATA: begin
        r_wr_next[grant_q] = app_wr_next_req;
        app_wr_en_n        = r_wr_en_n[int'(grant_q)*APP_BW +: APP_BW];
      end
      RDATA: begin
        r_rd_valid[grant_q] = app_rd_valid;
        r_last_rd[grant_q]  = app_rd_valid & app_last_rd;
      end
      default: ;
    endcase
  end

  assign app_wr_data  = r_wr_data[int'(grant_q)*APP_DW +: APP_DW];
  assign r_rd_data    = app_rd_data;
  assign app_req      = app_req_q;
  assign app_req_addr = addr_q;
  assign app_req_len  = len_q;
  assign app_req_wr_n = wr_n_q;
  assign grant_id     = grant_q;
  assign arb_busy     = (state_q != IDLE);
  assign arb_err      = err_q;

endmodule
